bus_cycle_ctrl: RTL and testbench



---
 rtl/bus_cycle_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_bus_cycle_ctrl.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_cycle_ctrl.sv
// bus_cycle_ctrl: 68000 local-bus cycle sequencer that adds per-region wait states before DTACK_n.
// Define BUS_WATCHDOG_EN to build the timeout counter, the ERR state (BERR_n) and the sticky o_TIMEOUT flag.
module bus_cycle_ctrl #(
    parameter int RAM_WAIT       = 0,
    parameter int ROM_WAIT       = 2,
    parameter int IO_WAIT        = 3,
    parameter int TIMEOUT_CYCLES = 64,
    parameter int CNT_W          = 8
) (
    input  logic i_CLK,
    input  logic i_RST,
    input  logic i_AS_n,
    input  logic i_EVENRAM_n,
    input  logic i_ODDRAM_n,
    input  logic i_EVENROM_n,
    input  logic i_ODDROM_n,
    input  logic i_IOSEL_n,
    input  logic i_EXPSEL_n,
    input  logic i_EXPDTACK_n,
    output logic o_DTACK_n,
    output logic o_BERR_n,
    output logic o_BUSY,
    output logic o_TIMEOUT
);

    // Cycle handshake: a cycle opens when IDLE samples AS_n low; once DTACK_n (or BERR_n) is
    // asserted it stays asserted until AS_n is sampled high, so every strobe ends exactly once.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ACK  = 2'd2
`ifdef BUS_WATCHDOG_EN
        , ST_ERR = 2'd3
`endif
    } state_t;

    typedef enum logic [2:0] {
        RG_NONE = 3'd0,
        RG_RAM  = 3'd1,
        RG_ROM  = 3'd2,
        RG_IO   = 3'd3,
        RG_EXP  = 3'd4
    } region_t;

    state_t            state_q, state_d;
    region_t           region_q, region_d;
    region_t           sel_region;
    logic [CNT_W-1:0]  wait_cnt_q, wait_cnt_d;
    logic [CNT_W-1:0]  wait_load;
    logic              dtack_n_q, dtack_n_d;
    logic              ack_ready;

`ifdef BUS_WATCHDOG_EN
    logic [CNT_W-1:0]  to_cnt_q, to_cnt_d;
    logic              berr_n_q, berr_n_d;
    logic              timeout_q, timeout_d;
`endif

    // Several selects low is a decoder fault; resolve it as ROM > IO > RAM > EXP.
    always_comb begin
        sel_region = RG_NONE;
        if (!i_EVENROM_n || !i_ODDROM_n) begin
            sel_region = RG_ROM;
        end else if (!i_IOSEL_n) begin
            sel_region = RG_IO;
        end else if (!i_EVENRAM_n || !i_ODDRAM_n) begin
            sel_region = RG_RAM;
        end else if (!i_EXPSEL_n) begin
            sel_region = RG_EXP;
        end
    end

    always_comb begin
        wait_load = '0;
        case (sel_region)
            RG_RAM:  wait_load = CNT_W'(RAM_WAIT);
            RG_ROM:  wait_load = CNT_W'(ROM_WAIT);
            RG_IO:   wait_load = CNT_W'(IO_WAIT);
            default: wait_load = '0;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        region_d   = region_q;
        wait_cnt_d = wait_cnt_q;
        ack_ready  = 1'b0;
`ifdef BUS_WATCHDOG_EN
        to_cnt_d   = to_cnt_q;
        timeout_d  = timeout_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (!i_AS_n) begin
                    state_d    = ST_WAIT;
                    region_d   = sel_region;
                    wait_cnt_d = wait_load;
`ifdef BUS_WATCHDOG_EN
                    to_cnt_d   = '0;
`endif
                end
            end
            ST_WAIT: begin
                wait_cnt_d = (wait_cnt_q == '0) ? '0 : wait_cnt_q - CNT_W'(1);
`ifdef BUS_WATCHDOG_EN
                to_cnt_d   = to_cnt_q + CNT_W'(1);
`endif
                case (region_q)
                    RG_RAM, RG_ROM, RG_IO: ack_ready = (wait_cnt_q == '0);
                    RG_EXP:                ack_ready = !i_EXPDTACK_n;
                    default:               ack_ready = 1'b0;
                endcase
                // Abort beats everything; an acknowledge beats a same-edge watchdog expiry.
                if (i_AS_n) begin
                    state_d = ST_IDLE;
                end else if (ack_ready) begin
                    state_d = ST_ACK;
`ifdef BUS_WATCHDOG_EN
                end else if (to_cnt_d == CNT_W'(TIMEOUT_CYCLES)) begin
                    state_d   = ST_ERR;
                    timeout_d = 1'b1;
`endif
                end
            end
            ST_ACK: begin
                if (i_AS_n) begin
                    state_d = ST_IDLE;
                end
            end
`ifdef BUS_WATCHDOG_EN
            ST_ERR: begin
                if (i_AS_n) begin
                    state_d = ST_IDLE;
                end
            end
`endif
            default: state_d = ST_IDLE;
        endcase

        dtack_n_d = (state_d != ST_ACK);
`ifdef BUS_WATCHDOG_EN
        berr_n_d  = (state_d != ST_ERR);
`endif
    end

    always_ff @(posedge i_CLK) begin
        if (i_RST) begin
            state_q    <= ST_IDLE;
            region_q   <= RG_NONE;
            wait_cnt_q <= '0;
            dtack_n_q  <= 1'b1;
`ifdef BUS_WATCHDOG_EN
            to_cnt_q   <= '0;
            berr_n_q   <= 1'b1;
            timeout_q  <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            region_q   <= region_d;
            wait_cnt_q <= wait_cnt_d;
            dtack_n_q  <= dtack_n_d;
`ifdef BUS_WATCHDOG_EN
            to_cnt_q   <= to_cnt_d;
            berr_n_q   <= berr_n_d;
            timeout_q  <= timeout_d;
`endif
        end
    end

    assign o_DTACK_n = dtack_n_q;
    assign o_BUSY    = (state_q != ST_IDLE);

`ifdef BUS_WATCHDOG_EN
    assign o_BERR_n  = berr_n_q;
    assign o_TIMEOUT = timeout_q;
`else
    // No watchdog: bus error never asserts; the flag evaluates to 0 for any legal TIMEOUT_CYCLES.
    assign o_BERR_n  = 1'b1;
    assign o_TIMEOUT = (TIMEOUT_CYCLES == 0);
`endif

endmodule

// File: tb/tb_bus_cycle_ctrl.sv
// Bench for bus_cycle_ctrl: fixed vector table, hand-written multi-cycle sequences, and random
// cycles checked every edge against a timestamp-based model of the bus-cycle rules.
module tb_bus_cycle_ctrl;

    localparam int RAM_W = 0;
    localparam int ROM_W = 2;
    localparam int IO_W  = 3;
    localparam int TO    = 64;
`ifdef BUS_WATCHDOG_EN
    localparam bit WDOG = 1'b1;
`else
    localparam bit WDOG = 1'b0;
`endif

    // sel bits, all active low: [5] EVENRAM [4] ODDRAM [3] EVENROM [2] ODDROM [1] IOSEL [0] EXPSEL
    localparam logic [5:0] SEL_NONE    = 6'b111111;
    localparam logic [5:0] SEL_RAM_E   = 6'b011111;
    localparam logic [5:0] SEL_RAM_O   = 6'b101111;
    localparam logic [5:0] SEL_ROM_E   = 6'b110111;
    localparam logic [5:0] SEL_ROM_O   = 6'b111011;
    localparam logic [5:0] SEL_IO      = 6'b111101;
    localparam logic [5:0] SEL_EXP     = 6'b111110;
    localparam logic [5:0] SEL_ROM_RAM = 6'b010111;

    logic       clk;
    logic       rst;
    logic       as_n;
    logic [5:0] sel;
    logic       expd_n;
    logic       dtack_n, berr_n, busy, timeout;

    int total = 0;
    int bad   = 0;

    bus_cycle_ctrl #(
        .RAM_WAIT(RAM_W), .ROM_WAIT(ROM_W), .IO_WAIT(IO_W),
        .TIMEOUT_CYCLES(TO), .CNT_W(8)
    ) dut (
        .i_CLK(clk),
        .i_RST(rst),
        .i_AS_n(as_n),
        .i_EVENRAM_n(sel[5]),
        .i_ODDRAM_n(sel[4]),
        .i_EVENROM_n(sel[3]),
        .i_ODDROM_n(sel[2]),
        .i_IOSEL_n(sel[1]),
        .i_EXPSEL_n(sel[0]),
        .i_EXPDTACK_n(expd_n),
        .o_DTACK_n(dtack_n),
        .o_BERR_n(berr_n),
        .o_BUSY(busy),
        .o_TIMEOUT(timeout)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL global_time_limit: simulation still running, required finish");
        $fatal(1, "time limit");
    end

    // ---------------- reference model ----------------
    // A cycle is a start timestamp plus a region; termination is decided by elapsed edges.
    int edge_n   = 0;
    bit m_active = 1'b0;
    bit m_ack    = 1'b0;
    bit m_err    = 1'b0;
    bit m_tout   = 1'b0;
    int m_start  = 0;
    int m_region = 0;   // 0 none, 1 ram, 2 rom, 3 io, 4 exp

    function automatic int pick_region(input logic [5:0] s);
        if (!s[3] || !s[2]) return 2;
        if (!s[1])          return 3;
        if (!s[5] || !s[4]) return 1;
        if (!s[0])          return 4;
        return 0;
    endfunction

    function automatic bit ack_due(input int region, input int elapsed, input logic ed_n);
        case (region)
            1: return elapsed >= 1 + RAM_W;
            2: return elapsed >= 1 + ROM_W;
            3: return elapsed >= 1 + IO_W;
            4: return !ed_n;
            default: return 1'b0;
        endcase
    endfunction

    task automatic model_edge();
        int elapsed;
        edge_n++;
        if (rst) begin
            m_active = 1'b0; m_ack = 1'b0; m_err = 1'b0; m_tout = 1'b0;
        end else if (!m_active) begin
            if (!as_n) begin
                m_active = 1'b1; m_start = edge_n; m_region = pick_region(sel);
            end
        end else if (m_ack || m_err) begin
            if (as_n) begin
                m_active = 1'b0; m_ack = 1'b0; m_err = 1'b0;
            end
        end else begin
            elapsed = edge_n - m_start;
            if (as_n) m_active = 1'b0;
            else if (ack_due(m_region, elapsed, expd_n)) m_ack = 1'b1;
            else if (WDOG && elapsed == TO) begin
                m_err = 1'b1; m_tout = 1'b1;
            end
        end
    endtask

    // ---------------- scoreboard / driver ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic r, input logic a, input logic [5:0] s, input logic e);
        rst = r; as_n = a; sel = s; expd_n = e;
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        check("model_dtack",   {31'd0, dtack_n}, {31'd0, !m_ack});
        check("model_berr",    {31'd0, berr_n},  {31'd0, !m_err});
        check("model_busy",    {31'd0, busy},    {31'd0, m_active});
        check("model_timeout", {31'd0, timeout}, {31'd0, m_tout});
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic       rst;
        logic       as_n;
        logic [5:0] sel;
        logic       expd_n;
        logic       dtack_n;
        logic       berr_n;
        logic       busy;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, input logic a, input logic [5:0] s,
                       input logic dt, input logic bs);
        vec_t v;
        v.rst = r; v.as_n = a; v.sel = s; v.expd_n = 1'b1;
        v.dtack_n = dt; v.berr_n = 1'b1; v.busy = bs;
        vecs.push_back(v);
    endtask

    initial begin
        int berr_edge;
        int dt_edge;
        bit busy_drop;
        logic [5:0] rs;
        int hold;

        drive(1'b1, 1'b1, SEL_NONE, 1'b1);

        // reset
        add(1, 1, SEL_NONE, 1, 0);  add(1, 1, SEL_NONE, 1, 0);
        // RAM: DTACK after k+1
        add(0, 0, SEL_RAM_E, 1, 1); add(0, 0, SEL_RAM_E, 0, 1); add(0, 0, SEL_RAM_E, 0, 1);
        add(0, 1, SEL_NONE, 1, 0);  add(0, 1, SEL_NONE, 1, 0);
        // ROM: DTACK after k+3
        add(0, 0, SEL_ROM_O, 1, 1); add(0, 0, SEL_ROM_O, 1, 1); add(0, 0, SEL_ROM_O, 1, 1);
        add(0, 0, SEL_ROM_O, 0, 1); add(0, 1, SEL_NONE, 1, 0);
        // IO: DTACK after k+4
        add(0, 0, SEL_IO, 1, 1); add(0, 0, SEL_IO, 1, 1); add(0, 0, SEL_IO, 1, 1);
        add(0, 0, SEL_IO, 1, 1); add(0, 0, SEL_IO, 0, 1); add(0, 1, SEL_NONE, 1, 0);
        // ROM+RAM both low: ROM timing
        add(0, 0, SEL_ROM_RAM, 1, 1); add(0, 0, SEL_ROM_RAM, 1, 1); add(0, 0, SEL_ROM_RAM, 1, 1);
        add(0, 0, SEL_ROM_RAM, 0, 1); add(0, 1, SEL_NONE, 1, 0);
        // IO abort at k+2: never acknowledged
        add(0, 0, SEL_IO, 1, 1); add(0, 0, SEL_IO, 1, 1); add(0, 1, SEL_IO, 1, 0);
        add(0, 1, SEL_NONE, 1, 0);
        // select change mid-cycle is ignored (RAM latched)
        add(0, 0, SEL_RAM_O, 1, 1); add(0, 0, SEL_IO, 0, 1); add(0, 1, SEL_NONE, 1, 0);
        // back-to-back: AS_n high for one edge between cycles
        add(0, 0, SEL_RAM_E, 1, 1); add(0, 0, SEL_RAM_E, 0, 1); add(0, 0, SEL_RAM_E, 0, 1);
        add(0, 1, SEL_RAM_E, 1, 0); add(0, 0, SEL_RAM_E, 1, 1); add(0, 0, SEL_RAM_E, 0, 1);
        add(0, 1, SEL_NONE, 1, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].rst, vecs[i].as_n, vecs[i].sel, vecs[i].expd_n);
            tick();
            check($sformatf("vec%0d_dtack", i), {31'd0, dtack_n}, {31'd0, vecs[i].dtack_n});
            check($sformatf("vec%0d_berr", i),  {31'd0, berr_n},  {31'd0, vecs[i].berr_n});
            check($sformatf("vec%0d_busy", i),  {31'd0, busy},    {31'd0, vecs[i].busy});
        end

        // expansion handshake: EXPDTACK_n low at k+5, AS_n high at k+8
        drive(0, 0, SEL_EXP, 1); tick();
        for (int i = 1; i <= 4; i++) begin
            tick();
            check("exp_wait_dtack", {31'd0, dtack_n}, 32'd1);
        end
        drive(0, 0, SEL_EXP, 0); tick();
        check("exp_ack_dtack", {31'd0, dtack_n}, 32'd0);
        drive(0, 0, SEL_EXP, 1); tick(); tick();
        check("exp_hold_dtack", {31'd0, dtack_n}, 32'd0);
        drive(0, 1, SEL_NONE, 1); tick();
        check("exp_release_dtack", {31'd0, dtack_n}, 32'd1);
        check("exp_release_busy",  {31'd0, busy},    32'd0);

        // race: EXP acknowledge sampled on the watchdog expiry edge
        drive(0, 0, SEL_EXP, 1); tick();
        for (int i = 1; i < TO; i++) tick();
        drive(0, 0, SEL_EXP, 0); tick();
        check("race_dtack",   {31'd0, dtack_n}, 32'd0);
        check("race_berr",    {31'd0, berr_n},  32'd1);
        check("race_timeout", {31'd0, timeout}, 32'd0);
        drive(0, 1, SEL_NONE, 1); tick();

        // unselected cycle held 70 clocks
        drive(0, 0, SEL_NONE, 1); tick();
        berr_edge = -1; dt_edge = -1; busy_drop = 1'b0;
        for (int i = 1; i <= 70; i++) begin
            tick();
            if (berr_edge < 0 && berr_n == 1'b0) berr_edge = i;
            if (dt_edge < 0 && dtack_n == 1'b0) dt_edge = i;
            if (busy == 1'b0) busy_drop = 1'b1;
        end
        check("wd_no_dtack", dt_edge, -1);
        check("wd_busy_held", {31'd0, busy_drop}, 32'd0);
`ifdef BUS_WATCHDOG_EN
        check("wd_berr_edge", berr_edge, TO);
        check("wd_timeout_set", {31'd0, timeout}, 32'd1);
`else
        check("wd_berr_never", berr_edge, -1);
        check("wd_timeout_zero", {31'd0, timeout}, 32'd0);
`endif
        drive(0, 1, SEL_NONE, 1); tick();
        check("wd_release_berr", {31'd0, berr_n}, 32'd1);
        check("wd_release_busy", {31'd0, busy},   32'd0);
        check("wd_timeout_sticky", {31'd0, timeout}, {31'd0, WDOG});

        // reset held 3 clocks in the middle of an IO cycle
        drive(0, 0, SEL_IO, 1); tick(); tick();
        for (int i = 0; i < 3; i++) begin
            drive(1, 0, SEL_IO, 1); tick();
            check("rst_dtack",   {31'd0, dtack_n}, 32'd1);
            check("rst_berr",    {31'd0, berr_n},  32'd1);
            check("rst_busy",    {31'd0, busy},    32'd0);
            check("rst_timeout", {31'd0, timeout}, 32'd0);
        end
        drive(0, 1, SEL_NONE, 1); tick();

        // random cycles against the model
        for (int c = 0; c < 60; c++) begin
            case ($urandom_range(0, 7))
                0: rs = SEL_RAM_E;
                1: rs = SEL_ROM_E;
                2: rs = SEL_IO;
                3: rs = SEL_EXP;
                4: rs = SEL_NONE;
                default: rs = 6'($urandom_range(0, 63));
            endcase
            hold = ($urandom_range(0, 9) == 0) ? $urandom_range(60, 72) : $urandom_range(0, 8);
            drive(0, 0, rs, 1); tick();
            for (int j = 0; j < hold; j++) begin
                drive(0, 0, 6'($urandom_range(0, 63)), ($urandom_range(0, 3) == 0) ? 1'b0 : 1'b1);
                tick();
            end
            drive(0, 1, SEL_NONE, 1); tick();
            if ($urandom_range(0, 1) == 0) tick();
            if ($urandom_range(0, 11) == 0) begin
                drive(1, $urandom_range(0, 1), SEL_NONE, 1); tick();
                drive(0, 1, SEL_NONE, 1); tick();
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
